// File: rtl/gtx_tx_startup_ctrl.sv
// TX bring-up sequencer for one GTX channel on the shared QPLL: QPLL reset, lock wait,
// GTTXRESET release, TXUSERRDY, TXRESETDONE wait, with automatic retry on timeout or lock loss.
module gtx_tx_startup_ctrl #(
    parameter int unsigned STABLE_CLOCK_PERIOD  = 8,
    parameter int unsigned RESET_PULSE_CYCLES   = 4,
    parameter int unsigned LOCK_TIMEOUT_NS      = 50000,
    parameter int unsigned RESETDONE_TIMEOUT_NS = 50000,
    parameter int unsigned USERRDY_DELAY        = 16
) (
    input  logic       STABLE_CLOCK,
    input  logic       SOFT_RESET_N,
    input  logic       QPLL_LOCK,
    input  logic       QPLL_REFCLKLOST,
    input  logic       TX_RESETDONE,
    output logic       QPLL_RESET,
    output logic       GTTXRESET,
    output logic       TXUSERRDY,
    output logic       TX_FSM_RESET_DONE,
    output logic [7:0] RETRY_COUNT
);
    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic int unsigned last_of(input int unsigned n);
        return (n > 0) ? n - 1 : 0;
    endfunction

    localparam int unsigned INIT_CYCLES = 500 / STABLE_CLOCK_PERIOD + 10;
    localparam int unsigned LOCK_CYCLES = LOCK_TIMEOUT_NS / STABLE_CLOCK_PERIOD;
    localparam int unsigned DONE_CYCLES = RESETDONE_TIMEOUT_NS / STABLE_CLOCK_PERIOD;
    localparam int unsigned MAX_CYCLES  = max2(max2(INIT_CYCLES, max2(LOCK_CYCLES, DONE_CYCLES)),
                                               max2(RESET_PULSE_CYCLES, USERRDY_DELAY));
    localparam int unsigned TIMER_W     = ($clog2(MAX_CYCLES + 1) > 20) ? $clog2(MAX_CYCLES + 1) : 20;

    localparam logic [TIMER_W-1:0] INIT_LAST    = TIMER_W'(last_of(INIT_CYCLES));
    localparam logic [TIMER_W-1:0] LOCK_LAST    = TIMER_W'(last_of(LOCK_CYCLES));
    localparam logic [TIMER_W-1:0] DONE_LAST    = TIMER_W'(last_of(DONE_CYCLES));
    localparam logic [TIMER_W-1:0] PULSE_LAST   = TIMER_W'(last_of(RESET_PULSE_CYCLES));
    localparam logic [TIMER_W-1:0] USERRDY_LAST = TIMER_W'(last_of(USERRDY_DELAY));

    typedef enum logic [2:0] {
        INIT_WAIT,
        ASSERT_QPLL_RESET,
        WAIT_LOCK,
        RELEASE_GT,
        WAIT_RESETDONE,
        ASSERT_GT_RESET,
        DONE
    } state_e;

    state_e               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [7:0]           retry_q, retry_d;
    logic                 retry_inc;
    logic [1:0]           lock_sync_q, lost_sync_q, done_sync_q;
    logic                 lock_s, lost_s, done_s, lock_bad;
    logic                 qpll_reset_q, qpll_reset_d;
    logic                 gttxreset_q, gttxreset_d;
    logic                 txuserrdy_q, txuserrdy_d;
    logic                 fsm_done_q, fsm_done_d;

    assign lock_s   = lock_sync_q[1];
    assign lost_s   = lost_sync_q[1];
    assign done_s   = done_sync_q[1];
    assign lock_bad = !lock_s || lost_s;

    // State register, shared timer, retry counter, input synchronizers and output flops
    always_ff @(posedge STABLE_CLOCK) begin
        if (!SOFT_RESET_N) begin
            state_q      <= INIT_WAIT;
            timer_q      <= '0;
            retry_q      <= '0;
            lock_sync_q  <= '0;
            lost_sync_q  <= '0;
            done_sync_q  <= '0;
            qpll_reset_q <= 1'b0;
            gttxreset_q  <= 1'b1;
            txuserrdy_q  <= 1'b0;
            fsm_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            retry_q      <= retry_d;
            lock_sync_q  <= {lock_sync_q[0], QPLL_LOCK};
            lost_sync_q  <= {lost_sync_q[0], QPLL_REFCLKLOST};
            done_sync_q  <= {done_sync_q[0], TX_RESETDONE};
            qpll_reset_q <= qpll_reset_d;
            gttxreset_q  <= gttxreset_d;
            txuserrdy_q  <= txuserrdy_d;
            fsm_done_q   <= fsm_done_d;
        end
    end

    // Next state; lock loss outranks resetdone and timeout in the same cycle
    always_comb begin
        state_d   = state_q;
        retry_inc = 1'b0;
        case (state_q)
            INIT_WAIT: begin
                if (timer_q == INIT_LAST) state_d = ASSERT_QPLL_RESET;
            end
            ASSERT_QPLL_RESET: begin
                if (timer_q == PULSE_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s && !lost_s) begin
                    state_d = RELEASE_GT;
                end else if (timer_q == LOCK_LAST) begin
                    state_d   = ASSERT_QPLL_RESET;
                    retry_inc = 1'b1;
                end
            end
            RELEASE_GT: begin
                if (lock_bad) begin
                    state_d   = ASSERT_QPLL_RESET;
                    retry_inc = 1'b1;
                end else if (timer_q == USERRDY_LAST) begin
                    state_d = WAIT_RESETDONE;
                end
            end
            WAIT_RESETDONE: begin
                if (lock_bad) begin
                    state_d   = ASSERT_QPLL_RESET;
                    retry_inc = 1'b1;
                end else if (done_s) begin
                    state_d = DONE;
                end else if (timer_q == DONE_LAST) begin
                    state_d   = ASSERT_GT_RESET;
                    retry_inc = 1'b1;
                end
            end
            ASSERT_GT_RESET: begin
                if (timer_q == PULSE_LAST) state_d = WAIT_LOCK;
            end
            DONE: begin
                if (lock_bad) begin
                    state_d   = ASSERT_QPLL_RESET;
                    retry_inc = 1'b1;
                end
            end
            default: state_d = INIT_WAIT;
        endcase

        if (state_d != state_q)   timer_d = '0;
        else if (timer_q == '1)   timer_d = timer_q;
        else                      timer_d = timer_q + TIMER_W'(1);

        retry_d = (retry_inc && retry_q != 8'hFF) ? retry_q + 8'd1 : retry_q;
    end

    // Outputs decoded from the upcoming state so the flops line up with the state register
    always_comb begin
        qpll_reset_d = 1'b0;
        gttxreset_d  = 1'b1;
        txuserrdy_d  = 1'b0;
        fsm_done_d   = 1'b0;
        case (state_d)
            ASSERT_QPLL_RESET: qpll_reset_d = 1'b1;
            RELEASE_GT:        gttxreset_d  = 1'b0;
            WAIT_RESETDONE: begin
                gttxreset_d = 1'b0;
                txuserrdy_d = 1'b1;
            end
            DONE: begin
                gttxreset_d = 1'b0;
                txuserrdy_d = 1'b1;
                fsm_done_d  = 1'b1;
            end
            default: ;
        endcase
    end

    assign QPLL_RESET        = qpll_reset_q;
    assign GTTXRESET         = gttxreset_q;
    assign TXUSERRDY         = txuserrdy_q;
    assign TX_FSM_RESET_DONE = fsm_done_q;
    assign RETRY_COUNT       = retry_q;

endmodule

// File: tb/tb_gtx_tx_startup_ctrl.sv
// Bench for gtx_tx_startup_ctrl: an analytic timeline of expected output changes is queued
// per scenario, and a monitor matches every observed output change against it.
module tb_gtx_tx_startup_ctrl;
    logic       STABLE_CLOCK = 1'b0;
    logic       SOFT_RESET_N;
    logic       QPLL_LOCK;
    logic       QPLL_REFCLKLOST;
    logic       TX_RESETDONE;
    logic       QPLL_RESET;
    logic       GTTXRESET;
    logic       TXUSERRDY;
    logic       TX_FSM_RESET_DONE;
    logic [7:0] RETRY_COUNT;

    gtx_tx_startup_ctrl #(
        .STABLE_CLOCK_PERIOD (8),
        .RESET_PULSE_CYCLES  (4),
        .LOCK_TIMEOUT_NS     (800),
        .RESETDONE_TIMEOUT_NS(800),
        .USERRDY_DELAY       (16)
    ) dut (
        .STABLE_CLOCK     (STABLE_CLOCK),
        .SOFT_RESET_N     (SOFT_RESET_N),
        .QPLL_LOCK        (QPLL_LOCK),
        .QPLL_REFCLKLOST  (QPLL_REFCLKLOST),
        .TX_RESETDONE     (TX_RESETDONE),
        .QPLL_RESET       (QPLL_RESET),
        .GTTXRESET        (GTTXRESET),
        .TXUSERRDY        (TXUSERRDY),
        .TX_FSM_RESET_DONE(TX_FSM_RESET_DONE),
        .RETRY_COUNT      (RETRY_COUNT)
    );

    // Output vector: {QPLL_RESET, GTTXRESET, TXUSERRDY, TX_FSM_RESET_DONE, RETRY_COUNT}
    typedef struct {
        int          cyc;
        logic [11:0] v;
    } ev_t;

    localparam logic [11:0] RST_V = {4'b0100, 8'd0};

    ev_t         exp_q[$];
    logic [11:0] exp_prev;
    logic [11:0] dut_v;
    int          n_total = 0;
    int          n_pass  = 0;
    int          cyc     = 0;
    bit          mon_en  = 1'b0;

    assign dut_v = {QPLL_RESET, GTTXRESET, TXUSERRDY, TX_FSM_RESET_DONE, RETRY_COUNT};

    always #5 STABLE_CLOCK = ~STABLE_CLOCK;
    always @(posedge STABLE_CLOCK) cyc <= cyc + 1;

    function automatic logic [11:0] ov(input logic [3:0] f, input int rc);
        return {f, 8'(rc)};
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Queue an expected output vector that appears just after edge e (only if it differs)
    task automatic expect_ev(input int e, input logic [11:0] v);
        ev_t ev;
        if (v != exp_prev) begin
            ev.cyc = e;
            ev.v   = v;
            exp_q.push_back(ev);
            exp_prev = v;
        end
    endtask

    task automatic to_edge(input int e);
        while (cyc < e) begin
            @(posedge STABLE_CLOCK);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    endtask

    task automatic check_drained(input string name);
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL %s_missing_events cyc=%0d pending=%0d next_cyc=%0d next_val=%h",
                      name, cyc, exp_q.size(), exp_q[0].cyc, exp_q[0].v);
        check({name, "_final"}, dut_v, exp_prev);
    endtask

    // Hold reset for `hold` edges; base is the last edge that samples reset low
    task automatic do_reset(input int hold, output int base);
        int e0;
        e0 = cyc;
        SOFT_RESET_N = 1'b0;
        expect_ev(e0 + 1, RST_V);
        to_edge(e0 + hold);
        SOFT_RESET_N = 1'b1;
        base = e0 + hold;
    endtask

    initial begin : monitor
        logic [11:0] prev;
        ev_t         ev;
        wait (mon_en);
        prev = dut_v;
        forever begin
            @(negedge STABLE_CLOCK);
            if (dut_v !== prev) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_change cyc=%0d got=%h want=no change", cyc, dut_v);
                end else begin
                    ev = exp_q.pop_front();
                    if (ev.cyc == cyc && ev.v === dut_v) n_pass++;
                    else $display("FAIL output_event got cyc=%0d val=%h want cyc=%0d val=%h",
                                  cyc, dut_v, ev.cyc, ev.v);
                end
                prev = dut_v;
            end
        end
    end

    initial begin : stim
        int b, b2, a, t, w, d, e, x, s;
        SOFT_RESET_N    = 1'b0;
        QPLL_LOCK       = 1'b0;
        QPLL_REFCLKLOST = 1'b0;
        TX_RESETDONE    = 1'b0;
        to_edge(2);
        check("reset_state", dut_v, RST_V);
        exp_prev = RST_V;
        mon_en   = 1'b1;

        // Nominal bring-up with random lock/resetdone arrival, then a 1-cycle lock drop in DONE
        do_reset(3, b);
        a = b + int'($urandom_range(20, 170));
        t = imax(a + 3, b + 77);
        w = t + 16;
        d = int'($urandom_range(t, w + 90));
        e = imax(d + 3, w + 1);
        expect_ev(b + 72, ov(4'b1100, 0));
        expect_ev(b + 76, ov(4'b0100, 0));
        expect_ev(t,      ov(4'b0000, 0));
        expect_ev(w,      ov(4'b0010, 0));
        expect_ev(e,      ov(4'b0011, 0));
        to_edge(a);
        QPLL_LOCK = 1'b1;
        to_edge(d);
        TX_RESETDONE = 1'b1;
        x = e + int'($urandom_range(5, 30));
        expect_ev(x + 3,  ov(4'b1100, 1));
        expect_ev(x + 7,  ov(4'b0100, 1));
        expect_ev(x + 8,  ov(4'b0000, 1));
        expect_ev(x + 24, ov(4'b0010, 1));
        expect_ev(x + 25, ov(4'b0011, 1));
        to_edge(x);
        QPLL_LOCK = 1'b0;
        to_edge(x + 1);
        QPLL_LOCK = 1'b1;
        to_edge(x + 40);
        check_drained("nominal");

        // Resetdone never arrives: GT-only retries, then refclk loss coinciding with done_s
        TX_RESETDONE = 1'b0;
        do_reset(3, b);
        expect_ev(b + 72, ov(4'b1100, 0));
        expect_ev(b + 76, ov(4'b0100, 0));
        expect_ev(b + 77, ov(4'b0000, 0));
        w = b + 93;
        expect_ev(w, ov(4'b0010, 0));
        for (int k = 1; k <= 3; k++) begin
            expect_ev(w + 100, ov(4'b0100, k));
            expect_ev(w + 105, ov(4'b0000, k));
            expect_ev(w + 121, ov(4'b0010, k));
            w = w + 121;
        end
        s = w + int'($urandom_range(5, 80));
        expect_ev(s + 3,  ov(4'b1100, 4));
        expect_ev(s + 7,  ov(4'b0100, 4));
        expect_ev(s + 8,  ov(4'b0000, 4));
        expect_ev(s + 24, ov(4'b0010, 4));
        expect_ev(s + 25, ov(4'b0011, 4));
        to_edge(s);
        TX_RESETDONE    = 1'b1;
        QPLL_REFCLKLOST = 1'b1;
        to_edge(s + 1);
        QPLL_REFCLKLOST = 1'b0;
        to_edge(s + 45);
        check_drained("resetdone_timeout");

        // No lock: reset lands in the 2nd cycle of the first retry pulse, then run to saturation
        QPLL_LOCK    = 1'b0;
        TX_RESETDONE = 1'b0;
        do_reset(3, b);
        expect_ev(b + 72,  ov(4'b1100, 0));
        expect_ev(b + 76,  ov(4'b0100, 0));
        expect_ev(b + 176, ov(4'b1100, 1));
        to_edge(b + 177);
        do_reset(3, b2);
        for (int k = 0; k <= 258; k++) begin
            expect_ev(b2 + 72 + 104 * k, ov(4'b1100, (k > 255) ? 255 : k));
            expect_ev(b2 + 76 + 104 * k, ov(4'b0100, (k > 255) ? 255 : k));
        end
        to_edge(b2 + 76 + 104 * 258 + 20);
        check_drained("lock_timeout");
        check("retry_saturated", {4'h0, RETRY_COUNT}, {4'h0, 8'hFF});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
